instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Requester side of the Instruction_Memory interface. Owns the program counter and drives
//  fromPC. Captures fullInstruction, which the memory returns one clock after each address.
//  Presents a registered IF/ID stage (instruction, PC, valid) to decode.
//  Handles decode stalls with a one-entry skid buffer, and handles branch/jump redirects.
// PARAMETERS
//  RESET_PC  32'd0  fetch address loaded on reset
//  PC_STEP   32'd1  PC increment per instruction (memory is word-indexed)
// PORTS
//  clock            in   1   single clock; all state updates on its rising edge
//  reset            in   1   asynchronous, active-high reset
//  fromPC           out  32  fetch address to Instruction_Memory; driven from a register
//  fullInstruction  in   32  memory data, = mem[fromPC of the previous cycle]
//  stall            in   1   decode cannot accept; hold the IF/ID outputs
//  redirect         in   1   taken branch/jump; restart fetch at redirectPC
//  redirectPC       in   32  redirect target
//  instrOut         out  32  IF/ID instruction
//  pcOut            out  32  IF/ID address of instrOut
//  pcNext           out  32  pcOut + PC_STEP (combinational, mod 2^32)
//  instrValid       out  1   IF/ID contents valid
// BEHAVIOUR
//  Reset (async): fetchPC(=fromPC)=RESET_PC; respValid=0; respPC=0; skidValid=0; skid regs=0;
//   instrOut=0; pcOut=0; instrValid=0; state=RUN.
//  Internal regs:
//   - respPC/respValid: describe the word on fullInstruction this cycle.
//   - skidInstr/skidPC/skidValid: skid buffer.
//  FSM states: RUN, HOLD. Priority at every edge: redirect > stall > advance.
//  RUN, !stall:
//   - IF/ID <= {fullInstruction, respPC, respValid}
//   - respPC <= fetchPC; respValid <= 1; fetchPC <= fetchPC + PC_STEP
//  RUN, stall:
//   - IF/ID and fetchPC hold
//   - skid <= {fullInstruction, respPC, respValid}; respPC <= fetchPC; respValid <= 1
//   - -> HOLD
//  HOLD, stall: all registers hold. fromPC is unchanged, so memory keeps returning mem[fetchPC].
//  HOLD, !stall:
//   - IF/ID <= skid; skidValid <= 0
//   - respPC <= fetchPC; respValid <= 1; fetchPC <= fetchPC + PC_STEP
//   - -> RUN. No bubble and no duplicate on release.
//  redirect (either state, with or without stall):
//   - fetchPC <= redirectPC; respValid <= 0; skidValid <= 0; instrValid <= 0
//   - instrOut/pcOut hold; -> RUN
//  Latency:
//   - address on fromPC -> instrValid with that word: 2 edges.
//   - redirect at edge t: first target word valid on IF/ID after edge t+2 (2 bubble cycles).
//  Arithmetic: all PC math is 32-bit unsigned; wraps 32'hFFFFFFFF + 1 -> 0, no flag.
//  Invalid IF/ID entries (instrValid=0) still hold defined values; decode ignores them.
//  Reset asserted mid-stall or mid-redirect: immediate return to reset values; in-flight word discarded.
// TESTING (mem[k] = 32'hA000_0000 + k)
//  1 Release reset, no stall -> fromPC 0,1,2,...; instrValid first 1 after 2nd edge with
//    pcOut=0, instrOut=A0000000; then one instruction per cycle in order.
//  2 Stall 3 cycles while IF/ID holds pc 4 -> IF/ID holds pc 4, fromPC frozen at 6;
//    after release the stream is pc 5,6,7 with no gap or repeat.
//  3 redirect=1, redirectPC=32'h40 -> instrValid=0 for 2 cycles, then pcOut=40,
//    instrOut=A0000040, then 41.
//  4 redirect and stall high together in HOLD -> skid discarded, state RUN,
//    first valid output pcOut=redirectPC.
//  5 redirectPC=32'hFFFFFFFF, no stall -> fromPC goes FFFFFFFF then 0; pcNext=0 when pcOut=FFFFFFFF.
//  6 Assert reset mid-stall (async, between edges) -> outputs 0 and fromPC=RESET_PC immediately;
//    clean restart after release.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: owns the PC, drives fromPC, captures fullInstruction one cycle
// later and presents a registered IF/ID stage with a one-entry skid buffer for stalls.
// Ports: clock, reset (async, active-high), fromPC, fullInstruction, stall, redirect,
//        redirectPC, instrOut, pcOut, pcNext, instrValid.
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'd0,
   parameter logic [31:0] PC_STEP  = 32'd1
) (
   input  logic        clock,
   input  logic        reset,
   output logic [31:0] fromPC,
   input  logic [31:0] fullInstruction,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirectPC,
   output logic [31:0] instrOut,
   output logic [31:0] pcOut,
   output logic [31:0] pcNext,
   output logic        instrValid
);

   typedef enum logic {RUN, HOLD} state_t;

   state_t      state;
   logic [31:0] fetchPC;
   logic [31:0] respPC;
   logic        respValid;
   logic [31:0] skidInstr;
   logic [31:0] skidPC;
   logic        skidValid;

   assign fromPC = fetchPC;
   assign pcNext = pcOut + PC_STEP;

   // respPC/respValid tag the word currently on fullInstruction.
   // In HOLD, fromPC is frozen so the memory keeps re-reading mem[fetchPC];
   // that word is picked up again on release, so nothing is lost or repeated.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= RUN;
         fetchPC    <= RESET_PC;
         respPC     <= 32'd0;
         respValid  <= 1'b0;
         skidInstr  <= 32'd0;
         skidPC     <= 32'd0;
         skidValid  <= 1'b0;
         instrOut   <= 32'd0;
         pcOut      <= 32'd0;
         instrValid <= 1'b0;
      end else if (redirect) begin
         fetchPC    <= redirectPC;
         respValid  <= 1'b0;
         skidValid  <= 1'b0;
         instrValid <= 1'b0;
         state      <= RUN;
      end else begin
         unique case (state)
            RUN: begin
               if (stall) begin
                  skidInstr <= fullInstruction;
                  skidPC    <= respPC;
                  skidValid <= respValid;
                  respPC    <= fetchPC;
                  respValid <= 1'b1;
                  state     <= HOLD;
               end else begin
                  instrOut   <= fullInstruction;
                  pcOut      <= respPC;
                  instrValid <= respValid;
                  respPC     <= fetchPC;
                  respValid  <= 1'b1;
                  fetchPC    <= fetchPC + PC_STEP;
               end
            end
            HOLD: begin
               if (!stall) begin
                  instrOut   <= skidInstr;
                  pcOut      <= skidPC;
                  instrValid <= skidValid;
                  skidValid  <= 1'b0;
                  respPC     <= fetchPC;
                  respValid  <= 1'b1;
                  fetchPC    <= fetchPC + PC_STEP;
                  state      <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: scoreboard bench for instruction_fetch_unit.
// Memory model returns mem[k] = 32'hA000_0000 + k one cycle after the address.
module tb_instruction_fetch_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] fromPC;
   logic [31:0] fullInstruction = 32'd0;
   logic        stall;
   logic        redirect;
   logic [31:0] redirectPC;
   logic [31:0] instrOut;
   logic [31:0] pcOut;
   logic [31:0] pcNext;
   logic        instrValid;

   int checks = 0;
   int errors = 0;
   logic [31:0] expQ[$];

   instruction_fetch_unit dut (
      .clock(clock),
      .reset(reset),
      .fromPC(fromPC),
      .fullInstruction(fullInstruction),
      .stall(stall),
      .redirect(redirect),
      .redirectPC(redirectPC),
      .instrOut(instrOut),
      .pcOut(pcOut),
      .pcNext(pcNext),
      .instrValid(instrValid)
   );

   always #5 clock = ~clock;

   always @(posedge clock)
      fullInstruction <= 32'hA000_0000 + fromPC;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      memWord = 32'hA000_0000 + a;
   endfunction

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic pushRange(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) expQ.push_back(base + 32'(i));
   endtask

   // Entry is consumed by decode at the coming edge if valid and not stalled/flushed.
   task automatic step();
      logic [31:0] e;
      if (instrValid && !stall && !redirect && !reset) begin
         check("sbHasEntry", 32'(expQ.size() > 0), 32'd1);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            check("sbPc", pcOut, e);
            check("sbInstr", instrOut, memWord(e));
            check("sbPcNext", pcNext, e + 32'd1);
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic drain(input int maxCycles);
      int n = 0;
      stall = 1'b0;
      redirect = 1'b0;
      while (expQ.size() > 0 && n < maxCycles) begin
         step();
         n++;
      end
      check("drainDone", 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      stall = 1'b0;
      redirect = 1'b0;
      redirectPC = 32'd0;
      #3;
      check("rstFromPC", fromPC, 32'd0);
      check("rstInstr", instrOut, 32'd0);
      check("rstPc", pcOut, 32'd0);
      check("rstValid", 32'(instrValid), 32'd0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;

      // 1: stream from reset
      pushRange(32'd0, 10);
      check("t1FromPC0", fromPC, 32'd0);
      step();
      check("t1Valid1", 32'(instrValid), 32'd0);
      check("t1FromPC1", fromPC, 32'd1);
      step();
      check("t1Valid2", 32'(instrValid), 32'd1);
      check("t1FirstPc", pcOut, 32'd0);
      check("t1FirstInstr", instrOut, 32'hA000_0000);
      repeat (4) step();
      check("t1Pc4", pcOut, 32'd4);
      check("t1FromPC6", fromPC, 32'd6);

      // 2: stall 3 cycles holding pc 4
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t2HoldPc", pcOut, 32'd4);
         check("t2HoldValid", 32'(instrValid), 32'd1);
         check("t2Frozen", fromPC, 32'd6);
      end
      drain(20);

      // 3: redirect to 0x40
      expQ.delete();
      pushRange(32'h40, 4);
      redirect = 1'b1;
      redirectPC = 32'h40;
      step();
      redirect = 1'b0;
      check("t3Bubble1", 32'(instrValid), 32'd0);
      check("t3FromPC", fromPC, 32'h40);
      step();
      check("t3Bubble2", 32'(instrValid), 32'd0);
      step();
      check("t3FirstValid", 32'(instrValid), 32'd1);
      check("t3FirstPc", pcOut, 32'h40);
      drain(20);

      // 4: redirect with stall while in HOLD
      stall = 1'b1;
      step();
      step();
      expQ.delete();
      pushRange(32'h80, 3);
      redirect = 1'b1;
      redirectPC = 32'h80;
      step();
      redirect = 1'b0;
      stall = 1'b0;
      check("t4Flushed", 32'(instrValid), 32'd0);
      check("t4FromPC", fromPC, 32'h80);
      drain(20);

      // 5: PC wrap
      expQ.delete();
      expQ.push_back(32'hFFFF_FFFF);
      pushRange(32'd0, 3);
      redirect = 1'b1;
      redirectPC = 32'hFFFF_FFFF;
      step();
      redirect = 1'b0;
      check("t5FromPCMax", fromPC, 32'hFFFF_FFFF);
      step();
      check("t5FromPCWrap", fromPC, 32'd0);
      step();
      check("t5PcMax", pcOut, 32'hFFFF_FFFF);
      check("t5PcNextWrap", pcNext, 32'd0);
      drain(20);

      // 6: async reset mid-stall
      stall = 1'b1;
      step();
      step();
      #2;
      reset = 1'b1;
      #1;
      check("t6FromPC", fromPC, 32'd0);
      check("t6Instr", instrOut, 32'd0);
      check("t6Pc", pcOut, 32'd0);
      check("t6Valid", 32'(instrValid), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      stall = 1'b0;
      expQ.delete();
      pushRange(32'd0, 5);
      drain(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
